bf_wb_buffer: RTL
=================

# bf_wb_buffer

Writeback buffer directly downstream of the configurable butterfly (`a_o`/`b_o` outputs). It carries the destination addresses of each issued butterfly through a fixed-latency delay line matching the butterfly pipeline and captures the matching result pair. It queues each result pair, with its addresses, in a FIFO that drains to the coefficient memory under a valid/ready handshake. Because the butterfly pipeline cannot stall, the block gives the upstream scheduler a credit-based `issue_ready`, so the FIFO can never overflow.

## Interface
Parameters:
- `DW`, 256, butterfly output width.
- `AW`, 10, coefficient address width.
- `LAT`, 9, cycles from issue to valid `a_o`/`b_o`; legal range 1..32.
- `DEPTH`, 16, FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  the only clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `issue_vld`  in  1  butterfly operands presented to the butterfly this cycle.
- `issue_addr_a`, `issue_addr_b`  in  AW  destination addresses for the upper and lower results.
- `issue_ready`  out  1  credit available; an issue is accepted only when `issue_vld & issue_ready`.
- `bf_a_i`, `bf_b_i`  in  DW  butterfly `a_o`/`b_o`.
- `wr_vld`  out  1  head FIFO entry valid.
- `wr_rdy`  in  1  memory accepts the head entry.
- `wr_addr_a`, `wr_addr_b`  out  AW  head entry addresses.
- `wr_data_a`, `wr_data_b`  out  DW  head entry data.
- `idle`  out  1  FIFO empty and no issue in flight.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Accepted issue: push `{1, addr_a, addr_b}` into an LAT-stage valid/address delay line. A non-accepted cycle pushes an invalid token.
- Delay-line tap: when the token at stage LAT is valid, write `{addr_a, addr_b, bf_a_i, bf_b_i}` into the FIFO on that edge.
- FIFO: first-word-fall-through. `wr_*` always reflect the head entry, and `wr_vld = (count != 0)`. A pop occurs on `wr_vld & wr_rdy`.
- Credit accounting:
  - `inflight` counts valid tokens in the delay line (0..LAT).
  - `issue_ready = (count + inflight) < DEPTH`, computed from registered values only.
  - Push-only, pop-only and push+pop cycles update `count` by +1, −1 and 0 respectively.
  - An accept and a tap in the same cycle leave `inflight` unchanged.
- Full FIFO: credits guarantee a push never meets a full FIFO; no drop path exists.
- `issue_vld=1` while `issue_ready=0`: the issue is ignored, no token is inserted, and `err` is set.
- Read/write pointers wrap modulo DEPTH. `count` is a separate log2(DEPTH)+1-bit register.
- `wr_rdy` without `wr_vld`: no effect.
- `idle = (count==0) & (inflight==0)`.

## Timing
- Issue accepted in cycle t. The butterfly result is sampled at the end of cycle t+LAT, and `wr_vld` rises in cycle t+LAT+1 at the earliest. Issue-to-write latency is LAT+1 cycles.
- Back-to-back issues produce back-to-back writes while `wr_rdy=1`.
- Result order equals issue order.
- Reset values: FIFO empty, pointers 0, `count`=0, `inflight`=0, all delay-line tokens invalid, `wr_vld`=0, `issue_ready`=1, `idle`=1, `err`=0.
  - `wr_addr_*`/`wr_data_*` are don't-care while `wr_vld`=0.
- Reset mid-operation: in-flight tokens and queued entries are discarded. Any butterfly output arriving after reset is not captured.

## Configuration
- `BF_WB_COLLIDE_CHK_EN`
  - Defined: an accepted-looking issue with `issue_addr_a == issue_addr_b` is rejected. No token is inserted, no credit is used, and `err` is set.
  - Undefined: no comparison logic is built and such issues are queued normally. `err` reflects only the ready-violation case.

## Test plan
All scenarios use LAT=9, DEPTH=16.
1. Single issue at cycle 5 (addr_a=0x004, addr_b=0x204), `bf_a_i`=0xAA.., `bf_b_i`=0x55.. at cycle 14, `wr_rdy`=1 → `wr_vld` high in cycle 15 only, with those addresses and data; `idle` returns to 1 in cycle 16.
2. Hold `wr_rdy`=0 and issue every cycle → exactly 16 issues accepted, `issue_ready` low from the cycle after the 16th accept; after 25 cycles `count`=16 and `err`=0. Then `wr_rdy`=1 → 16 writes in issue order, and `issue_ready` rises the cycle after the first pop.
3. Continuous issue with `wr_rdy`=1 → steady-state one write per cycle, `issue_ready` never drops, output order matches issue order.
4. `issue_vld`=1 with `issue_ready`=0 (FIFO full) → no extra write ever appears, `err`=1 and stays set until `rst`.
5. Reset asserted with 5 in flight and 3 queued → next cycle `wr_vld`=0, `idle`=1, `issue_ready`=1; no writes follow.
6. Issue with addr_a=addr_b=0x010 → with `BF_WB_COLLIDE_CHK_EN`: no write, `err`=1. Without: one write at LAT+1, `err`=0.

Source files
------------

// File: rtl/bf_wb_buffer_if.sv
// rtl/bf_wb_buffer_if.sv - issue, butterfly-result and memory-write signals of the writeback buffer
interface bf_wb_buffer_if #(
  parameter int DW = 256,
  parameter int AW = 10
);
  logic          issue_vld;
  logic [AW-1:0] issue_addr_a;
  logic [AW-1:0] issue_addr_b;
  logic          issue_ready;
  logic [DW-1:0] bf_a_i;
  logic [DW-1:0] bf_b_i;
  logic          wr_vld;
  logic          wr_rdy;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;
  logic [DW-1:0] wr_data_a;
  logic [DW-1:0] wr_data_b;
  logic          idle;
  logic          err;

  modport slave (
    input  issue_vld, issue_addr_a, issue_addr_b, bf_a_i, bf_b_i, wr_rdy,
    output issue_ready, wr_vld, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b, idle, err
  );

  modport master (
    output issue_vld, issue_addr_a, issue_addr_b, bf_a_i, bf_b_i, wr_rdy,
    input  issue_ready, wr_vld, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b, idle, err
  );
endinterface

// File: rtl/bf_wb_buffer.sv
// rtl/bf_wb_buffer.sv - butterfly writeback buffer: address delay line, FWFT FIFO, issue credits
// Optional BF_WB_COLLIDE_CHK_EN rejects issues whose two destination addresses are equal.
module bf_wb_buffer #(
  parameter int DW    = 256,
  parameter int AW    = 10,
  parameter int LAT   = 9,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  bf_wb_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(LAT + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [LAT-1:0] tok_vld;
  logic [AW-1:0]  tok_a [LAT];
  logic [AW-1:0]  tok_b [LAT];

  logic [AW-1:0]  mem_a  [DEPTH];
  logic [AW-1:0]  mem_b  [DEPTH];
  logic [DW-1:0]  mem_da [DEPTH];
  logic [DW-1:0]  mem_db [DEPTH];

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [IW-1:0]  inflight;
  logic           err_q;

  logic [SW-1:0]  credit_sum;
  logic           credit_ok;
  logic           collide;
  logic           accept;
  logic           push;
  logic           pop;
  logic           fifo_vld;

  // Credits cover both queued entries and results still inside the butterfly pipe.
  assign credit_sum = SW'(count) + SW'(inflight);
  assign credit_ok  = credit_sum < SW'(DEPTH);

`ifdef BF_WB_COLLIDE_CHK_EN
  assign collide = (bus.issue_addr_a == bus.issue_addr_b);
`else
  assign collide = 1'b0;
`endif

  assign accept   = bus.issue_vld & credit_ok & ~collide;
  assign push     = tok_vld[LAT-1];
  assign fifo_vld = (count != '0);
  assign pop      = fifo_vld & bus.wr_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      tok_vld <= '0;
    end else begin
      tok_vld[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        tok_vld[i] <= tok_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tok_a[0] <= bus.issue_addr_a;
    tok_b[0] <= bus.issue_addr_b;
    for (int i = 1; i < LAT; i++) begin
      tok_a[i] <= tok_a[i-1];
      tok_b[i] <= tok_b[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= tok_a[LAT-1];
      mem_b[wr_ptr]  <= tok_b[LAT-1];
      mem_da[wr_ptr] <= bus.bf_a_i;
      mem_db[wr_ptr] <= bus.bf_b_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({accept, push})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
      if (bus.issue_vld & (~credit_ok | collide)) err_q <= 1'b1;
    end
  end

  assign bus.issue_ready = credit_ok;
  assign bus.wr_vld      = fifo_vld;
  assign bus.wr_addr_a   = mem_a[rd_ptr];
  assign bus.wr_addr_b   = mem_b[rd_ptr];
  assign bus.wr_data_a   = mem_da[rd_ptr];
  assign bus.wr_data_b   = mem_db[rd_ptr];
  assign bus.idle        = (count == '0) && (inflight == '0);
  assign bus.err         = err_q;
endmodule
